morse_pulse_classifier: RTL
===========================

MORSE_PULSE_CLASSIFIER -- requirements
Module: morse_pulse_classifier

Interface
REQ-001 Parameter TICK_DIV, default 50000: clk cycles per timing tick (legal range 2..2^20).
REQ-002 Parameter MIN_MARK, default 1: marks shorter than this many ticks are glitches.
REQ-003 Parameter DASH_MIN, default 3: marks of at least this many ticks are dashes.
REQ-004 Parameter CHAR_GAP, default 3: key-up ticks that end a character; CHAR_GAP >= 1.
REQ-005 Parameter HOLD_CYCLES, default 65536: clk cycles each symbol is held on parallel_out; HOLD_CYCLES >= 1.
REQ-006 clk  in  1  sole clock; all flops update on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-low; rst=0 at a rising clk edge resets the block.
REQ-008 serial_inp  in  1  asynchronous Morse key, 1 = key down (mark).
REQ-009 parallel_out  out  2  symbol code to the decoder FSM: 00 none, 01 dot, 10 dash, 11 end-of-character.
REQ-010 sym_valid  out  1  one-clk strobe on each new symbol.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 overrun  out  1  sticky flag, set when a symbol replaces one still in hold.

Function
REQ-013 serial_inp SHALL pass through a 2-flop synchronizer (key_s); all logic uses key_s only.
REQ-014 A prescaler SHALL pulse tick every TICK_DIV clk cycles; it restarts at 0 on every MARK/SPACE entry.
REQ-015 States: IDLE, MARK, SPACE; 8-bit mark_cnt and gap_cnt count ticks and saturate at 255.
REQ-016 IDLE: key_s=1 -> MARK, mark_cnt=0, from_space=0; else stay.
REQ-017 SPACE: key_s=1 -> MARK, mark_cnt=0, from_space=1; gap_cnt reaching CHAR_GAP -> emit 11, go IDLE.
REQ-018 MARK, key_s=0: mark_cnt < MIN_MARK -> no emit, go IDLE if from_space=0, else SPACE with gap_cnt=0.
REQ-019 MARK, key_s=0: MIN_MARK <= mark_cnt < DASH_MIN -> emit 01; mark_cnt >= DASH_MIN -> emit 10; both go SPACE, gap_cnt=0.
REQ-020 Emit: parallel_out <= code, sym_valid=1 for that one cycle, hold counter <= HOLD_CYCLES-1.
REQ-021 Hold counter decrements each cycle; parallel_out SHALL return to 00 the cycle after it reaches 0.
REQ-022 Emit while hold counter nonzero: new code replaces old, hold restarts, overrun <= 1.
REQ-023 Latency: serial_inp falling edge at clk edge k -> parallel_out/sym_valid updated at edge k+3.
REQ-024 A key held indefinitely SHALL stay in MARK (mark_cnt saturated); release yields 10.
REQ-025 Code 11 SHALL never follow IDLE or a glitch-only sequence; only a SPACE entered via dot/dash produces it.
REQ-026 overrun clears only on reset.

Reset
REQ-027 rst=0: state=IDLE, counters=0, synchronizer=0, parallel_out=00, sym_valid=0, busy=0, overrun=0.
REQ-028 Reset mid-MARK or mid-hold SHALL discard the pending symbol; nothing is emitted after release of rst.
REQ-029 With rst=0 held, outputs SHALL stay at reset values regardless of serial_inp.

Verification (TICK_DIV=4, MIN_MARK=1, DASH_MIN=3, CHAR_GAP=3, HOLD_CYCLES=8)
REQ-030 Dot: serial_inp high 8 cycles then low -> parallel_out=01 for 8 cycles, 1 sym_valid, then 11 about 12 cycles after release, busy=0.
REQ-031 Dash: high 16 cycles -> 10 held 8 cycles; then after 12 low cycles -> 11; "-.-" sequence (K) -> 10,01,10,11.
REQ-032 Glitch: high 2 cycles from IDLE -> parallel_out stays 00, no sym_valid, returns to IDLE.
REQ-033 Overrun: HOLD_CYCLES=64, dot then gap 6 cycles then dot -> second 01 restarts hold, overrun=1 until reset.
REQ-034 Reset mid-dash (rst=0 after 10 high cycles) -> all outputs reset values; release with key low -> no symbol.
REQ-035 Long key: high 2000 cycles -> single 10 after release, no wrap to dot.

Source files
------------

// File: rtl/morse_pulse_classifier_if.sv
// Key input and symbol output bundle for the Morse pulse classifier.
// The slave side is the classifier; the master side drives the key and
// consumes the symbols.
interface morse_pulse_classifier_if;
  logic       serial_inp;
  logic [1:0] parallel_out;
  logic       sym_valid;
  logic       busy;
  logic       overrun;

  modport master (
    output serial_inp,
    input  parallel_out,
    input  sym_valid,
    input  busy,
    input  overrun
  );

  modport slave (
    input  serial_inp,
    output parallel_out,
    output sym_valid,
    output busy,
    output overrun
  );
endinterface

// File: rtl/morse_pulse_classifier.sv
// Morse key pulse classifier: times key-down (mark) and key-up (space)
// intervals in prescaled ticks and emits dot / dash / end-of-character codes.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no character in progress, waiting for key down
// MARK  | key down, counting mark ticks (saturating at 255)
// SPACE | key up after a symbol, counting gap ticks toward end-of-char
module morse_pulse_classifier #(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned MIN_MARK    = 1,
  parameter int unsigned DASH_MIN    = 3,
  parameter int unsigned CHAR_GAP    = 3,
  parameter int unsigned HOLD_CYCLES = 65536
) (
  input logic                      clk,
  input logic                      rst,
  morse_pulse_classifier_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LOAD = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_DOT  = 2'b01;
  localparam logic [1:0] CODE_DASH = 2'b10;
  localparam logic [1:0] CODE_EOC  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            sync1;
  logic            key_s;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [7:0]      mark_cnt;
  logic [7:0]      gap_cnt;
  logic            from_space;
  logic            from_space_nxt;
  logic            enter;
  logic            emit;
  logic [1:0]      emit_code;
  logic            gap_last;
  logic [HW-1:0]   hold_cnt;
  logic [1:0]      code_q;
  logic            valid_q;
  logic            overrun_q;

  assign tick     = (presc == '0);
  assign gap_last = (({24'd0, gap_cnt} + 32'd1) >= CHAR_GAP);

  // Two-flop synchronizer on the asynchronous key input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      key_s <= 1'b0;
    end else begin
      sync1 <= bus.serial_inp;
      key_s <= sync1;
    end
  end

  // State register and the from_space marker for glitch handling.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      from_space <= 1'b0;
    end else begin
      state      <= state_nxt;
      from_space <= from_space_nxt;
    end
  end

  // Next-state decode; enter restarts the prescaler on every MARK/SPACE entry.
  always_comb begin
    state_nxt      = state;
    from_space_nxt = from_space;
    enter          = 1'b0;
    emit           = 1'b0;
    emit_code      = CODE_NONE;
    case (state)
      ST_IDLE: begin
        if (key_s) begin
          state_nxt      = ST_MARK;
          from_space_nxt = 1'b0;
          enter          = 1'b1;
        end
      end
      ST_MARK: begin
        if (!key_s) begin
          if ({24'd0, mark_cnt} < MIN_MARK) begin
            // Glitch: drop it; resume gap timing only if a character is open.
            state_nxt = from_space ? ST_SPACE : ST_IDLE;
            enter     = from_space;
          end else begin
            emit      = 1'b1;
            emit_code = ({24'd0, mark_cnt} >= DASH_MIN) ? CODE_DASH : CODE_DOT;
            state_nxt = ST_SPACE;
            enter     = 1'b1;
          end
        end
      end
      ST_SPACE: begin
        if (key_s) begin
          state_nxt      = ST_MARK;
          from_space_nxt = 1'b1;
          enter          = 1'b1;
        end else if (tick && gap_last) begin
          emit      = 1'b1;
          emit_code = CODE_EOC;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Tick prescaler as a down-counter; tick fires on terminal count zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc <= '0;
    end else if (enter) begin
      presc <= PRESC_LOAD;
    end else if (state != ST_IDLE) begin
      presc <= tick ? PRESC_LOAD : presc - 1'b1;
    end
  end

  // Saturating mark and gap tick counters, cleared on entry to their state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mark_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      if (enter && state_nxt == ST_MARK) begin
        mark_cnt <= '0;
      end else if (state == ST_MARK && tick && mark_cnt != 8'hFF) begin
        mark_cnt <= mark_cnt + 8'd1;
      end
      if (enter && state_nxt == ST_SPACE) begin
        gap_cnt <= '0;
      end else if (state == ST_SPACE && tick && gap_cnt != 8'hFF) begin
        gap_cnt <= gap_cnt + 8'd1;
      end
    end
  end

  // Symbol output with hold timer; a new symbol during hold sets overrun.
  always_ff @(posedge clk) begin
    if (!rst) begin
      code_q    <= CODE_NONE;
      valid_q   <= 1'b0;
      hold_cnt  <= '0;
      overrun_q <= 1'b0;
    end else if (emit) begin
      code_q   <= emit_code;
      valid_q  <= 1'b1;
      hold_cnt <= HOLD_LOAD;
      if (hold_cnt != '0) begin
        overrun_q <= 1'b1;
      end
    end else begin
      valid_q <= 1'b0;
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end else begin
        code_q <= CODE_NONE;
      end
    end
  end

  assign bus.parallel_out = code_q;
  assign bus.sym_valid    = valid_q;
  assign bus.overrun      = overrun_q;
  assign bus.busy         = (state != ST_IDLE);

endmodule
